// File: rtl/fabric_cfg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fabric_cfg_pkg
//  Description : Shared configuration-layout helpers and loader state codes
//                for io_block and its serial configuration loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package fabric_cfg_pkg;

    // Loader state encoding
    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_load  = 2'd1;
    localparam logic [1:0] c_st_check = 2'd2;

    // Bits needed to select one of the external input pins
    function automatic int sel_per_in(input int extin);
        return $clog2(extin);
    endfunction

    // Bits needed to select one of the single+double tracks
    function automatic int sel_per_out(input int ws, input int wd);
        return $clog2(ws + wd);
    endfunction

    // Total configuration width: input selects for every track, then output selects
    function automatic int cfg_width(input int ws, input int wd, input int wg,
                                     input int extin, input int extout);
        return sel_per_in(extin) * (ws + wd + wg) + sel_per_out(ws, wd) * extout;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_field_check.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_field_check
//  Description : Range check over a packed bus of equal-width select fields.
//                ok is high when every field is strictly below LIMIT.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_field_check #(
    parameter int          N_FIELDS = 1,
    parameter int          FIELD_W  = 1,
    parameter int unsigned LIMIT    = 1
) (
    input  logic [N_FIELDS*FIELD_W-1:0] fields,
    output logic                        ok
);

    logic [N_FIELDS-1:0] w_field_ok;

    // Compare each field at 32 bits so a LIMIT equal to 2**FIELD_W cannot overflow
    for (genvar gi = 0; gi < N_FIELDS; gi++) begin : g_field
        logic [FIELD_W-1:0] w_val;
        assign w_val          = fields[gi*FIELD_W +: FIELD_W];
        assign w_field_ok[gi] = (32'(w_val) < LIMIT);
    end

    assign ok = &w_field_ok;

endmodule
`default_nettype wire

// File: rtl/io_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : io_config_loader
//  Description : Serial LSB-first configuration loader for io_block. Bits are
//                collected into a shadow register, every select field is
//                range-checked, and a legal frame is committed atomically to c.
//  Revision    : 1.0 - initial release
// ============================================================================
module io_config_loader
    import fabric_cfg_pkg::*;
#(
    parameter  int WS          = 7,
    parameter  int WD          = 6,
    parameter  int WG          = 3,
    parameter  int EXTIN       = 5,
    parameter  int EXTOUT      = 2,
    localparam int SEL_PER_IN  = sel_per_in(EXTIN),
    localparam int SEL_PER_OUT = sel_per_out(WS, WD),
    localparam int CW          = cfg_width(WS, WD, WG, EXTIN, EXTOUT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_in,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    output logic [CW-1:0] c,
    output logic          cfg_done,
    output logic          cfg_err,
    output logic          cfg_busy
);

    localparam int N_IN_FIELDS = WS + WD + WG;
    localparam int IN_REGION_W = SEL_PER_IN * N_IN_FIELDS;
    localparam int CNT_W       = $clog2(CW + 1);
    localparam int IDX_W       = $clog2(CW);

    logic [1:0]      r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CW-1:0]   r_shadow;
    logic [CW-1:0]   r_c;
    logic            r_ready;
    logic            r_done;
    logic            r_err;
    logic            r_busy;

    logic            w_accept;
    logic [IDX_W-1:0] w_idx;
    logic            w_in_ok;
    logic            w_out_ok;

    // A restart request wins over a bit offered in the same cycle
    assign w_accept = r_ready & cfg_valid & ~cfg_start;
    // The counter never reaches CW while accepting, so the low bits index the shadow
    assign w_idx    = r_cnt[IDX_W-1:0];

    cfg_field_check #(
        .N_FIELDS (N_IN_FIELDS),
        .FIELD_W  (SEL_PER_IN),
        .LIMIT    (EXTIN)
    ) u_in_check (
        .fields   (r_shadow[IN_REGION_W-1:0]),
        .ok       (w_in_ok)
    );

    cfg_field_check #(
        .N_FIELDS (EXTOUT),
        .FIELD_W  (SEL_PER_OUT),
        .LIMIT    (WS + WD)
    ) u_out_check (
        .fields   (r_shadow[CW-1:IN_REGION_W]),
        .ok       (w_out_ok)
    );

    // Shadow register captures accepted bits; no reset, the counter and state gate its use
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_shadow[w_idx] <= cfg_in;
        end
    end

    // Loader FSM with counter, commit register and registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_c     <= '0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (cfg_start) begin
                        r_state <= c_st_load;
                        r_cnt   <= '0;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_load: begin
                    if (cfg_start) begin
                        r_cnt <= '0;
                    end else if (w_accept) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(CW - 1)) begin
                            r_state <= c_st_check;
                            r_ready <= 1'b0;
                        end
                    end
                end
                c_st_check: begin
                    if (w_in_ok && w_out_ok) begin
                        r_c    <= r_shadow;
                        r_done <= 1'b1;
                    end else begin
                        r_err  <= 1'b1;
                    end
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_st_idle;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_ready = r_ready;
    assign c         = r_c;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;
    assign cfg_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_io_config_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_io_config_loader
//  Description : Self-checking bench for io_config_loader. Frames are described
//                as lists of select values; the expected commit word and the
//                legality verdict are derived from those values directly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_io_config_loader;

    localparam int WS          = 7;
    localparam int WD          = 6;
    localparam int WG          = 3;
    localparam int EXTIN       = 5;
    localparam int EXTOUT      = 2;
    localparam int SEL_PER_IN  = $clog2(EXTIN);
    localparam int SEL_PER_OUT = $clog2(WS + WD);
    localparam int N_IN        = WS + WD + WG;
    localparam int CW          = SEL_PER_IN * N_IN + SEL_PER_OUT * EXTOUT;

    logic          clk;
    logic          rst;
    logic          cfg_start;
    logic          cfg_in;
    logic          cfg_valid;
    logic          cfg_ready;
    logic [CW-1:0] c;
    logic          cfg_done;
    logic          cfg_err;
    logic          cfg_busy;

    int n_checks;
    int n_fail;

    // Frame description and expected committed configuration
    int            f_in  [N_IN];
    int            f_out [EXTOUT];
    logic [CW-1:0] model_c;

    typedef struct {
        string name;
        int    in_val;
        int    out_val;
        int    bad_fld;   // -1: none; <N_IN: input field; else output field
        int    bad_val;
        int    bubble;    // percent of idle cycles
        bit    exp_ok;
    } vec_t;

    vec_t vecs [9];

    io_config_loader #(
        .WS     (WS),
        .WD     (WD),
        .WG     (WG),
        .EXTIN  (EXTIN),
        .EXTOUT (EXTOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_start (cfg_start),
        .cfg_in    (cfg_in),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .c         (c),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .cfg_busy  (cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Pack select values LSB-first, input selects first, then output selects
    function automatic logic [CW-1:0] model_pack();
        logic [CW-1:0] v;
        int pos;
        v   = '0;
        pos = 0;
        for (int f = 0; f < N_IN; f++)
            for (int b = 0; b < SEL_PER_IN; b++) begin
                v[pos] = ((f_in[f] >> b) & 1) != 0;
                pos++;
            end
        for (int f = 0; f < EXTOUT; f++)
            for (int b = 0; b < SEL_PER_OUT; b++) begin
                v[pos] = ((f_out[f] >> b) & 1) != 0;
                pos++;
            end
        return v;
    endfunction

    function automatic bit model_legal();
        bit ok;
        ok = 1'b1;
        for (int f = 0; f < N_IN; f++)   if (f_in[f]  >= EXTIN)   ok = 1'b0;
        for (int f = 0; f < EXTOUT; f++) if (f_out[f] >= WS + WD) ok = 1'b0;
        return ok;
    endfunction

    task automatic set_uniform(input int in_val, input int out_val);
        for (int f = 0; f < N_IN; f++)   f_in[f]  = in_val;
        for (int f = 0; f < EXTOUT; f++) f_out[f] = out_val;
    endtask

    // Start a frame and feed some bits without finishing it
    task automatic partial_load(input int nbits);
        int stray;
        stray = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'b0;
        @(negedge clk);
        cfg_start = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            cfg_valid = 1'b1;
            cfg_in    = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (cfg_done || cfg_err) stray++;
        end
        cfg_valid = 1'b0;
        chk("partial_no_pulse", stray, 0);
    endtask

    // Send the current frame with random bubbles and check cycle-exact completion
    task automatic run_frame(input int bubble_pct, input bit expect_ok);
        logic [CW-1:0] bits;
        int idx, guard, stray, rdy_bad;
        bit v;
        bits    = model_pack();
        idx     = 0;
        guard   = 0;
        stray   = 0;
        rdy_bad = 0;
        @(negedge clk);
        cfg_start = 1'b1;
        cfg_valid = 1'($urandom_range(0, 1));
        cfg_in    = 1'($urandom_range(0, 1));
        @(negedge clk);
        cfg_start = 1'b0;
        while (idx < CW && guard < 20000) begin
            if (!cfg_ready) rdy_bad++;
            if (cfg_done || cfg_err) stray++;
            v         = ($urandom_range(0, 99) >= bubble_pct);
            cfg_valid = v;
            cfg_in    = v ? bits[idx] : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (v) idx++;
            guard++;
        end
        cfg_valid = 1'b0;
        chk("frame_bits_sent", idx, CW);
        chk("ready_in_load", rdy_bad, 0);
        chk("no_early_pulse", stray, 0);
        // Check cycle: start requests here must be ignored
        chk("ready_in_check", cfg_ready, 0);
        chk("busy_in_check", cfg_busy, 1);
        chk("no_pulse_in_check", {cfg_done, cfg_err}, 0);
        chk("c_hold_in_check", c, model_c);
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        if (expect_ok) model_c = bits;
        chk("done_pulse", cfg_done, expect_ok);
        chk("err_pulse", cfg_err, !expect_ok);
        chk("c_after_frame", c, model_c);
        chk("busy_after_frame", cfg_busy, 0);
        @(negedge clk);
        chk("pulse_width", {cfg_done, cfg_err}, 0);
        chk("ready_idle", cfg_ready, 0);
        chk("busy_idle", cfg_busy, 0);
        chk("c_stable", c, model_c);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        model_c   = '0;
        rst       = 1'b1;
        cfg_start = 1'b0;
        cfg_in    = 1'b0;
        cfg_valid = 1'b0;

        vecs[0] = '{"legal_4_12",      4, 12, -1,        0,  0, 1'b1};
        vecs[1] = '{"bad_in0_5",       4, 12,  0,        5,  0, 1'b0};
        vecs[2] = '{"legal_bubbles",   4, 12, -1,        0, 50, 1'b1};
        vecs[3] = '{"legal_1_3",       1,  3, -1,        0, 20, 1'b1};
        vecs[4] = '{"legal_zero",      0,  0, -1,        0,  0, 1'b1};
        vecs[5] = '{"bad_out1_13",     2,  5, N_IN + 1, 13, 10, 1'b0};
        vecs[6] = '{"bad_glob_7",      3,  9, N_IN - 1,  7,  0, 1'b0};
        vecs[7] = '{"legal_max",       4, 12, -1,        0, 30, 1'b1};
        vecs[8] = '{"bad_out0_15",     4, 12, N_IN,     15,  0, 1'b0};

        // Reset held for two cycles
        repeat (2) @(negedge clk);
        chk("rst_c", c, 0);
        chk("rst_ready", cfg_ready, 0);
        chk("rst_busy", cfg_busy, 0);
        chk("rst_pulses", {cfg_done, cfg_err}, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_c", c, 0);
        chk("post_rst_ready", cfg_ready, 0);

        // Table-driven frames
        for (int k = 0; k < 9; k++) begin
            set_uniform(vecs[k].in_val, vecs[k].out_val);
            if (vecs[k].bad_fld >= N_IN)      f_out[vecs[k].bad_fld - N_IN] = vecs[k].bad_val;
            else if (vecs[k].bad_fld >= 0)    f_in[vecs[k].bad_fld]         = vecs[k].bad_val;
            run_frame(vecs[k].bubble, vecs[k].exp_ok);
        end

        // Restart after 20 bits: only the second frame may be committed
        partial_load(20);
        set_uniform(1, 3);
        run_frame(0, 1'b1);

        // Reset in the middle of a load discards the frame and clears c
        set_uniform(4, 12);
        run_frame(0, 1'b1);
        partial_load(30);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_c = '0;
        chk("midrst_c", c, 0);
        chk("midrst_busy", cfg_busy, 0);
        chk("midrst_ready", cfg_ready, 0);
        chk("midrst_pulses", {cfg_done, cfg_err}, 0);
        @(negedge clk);
        chk("midrst_no_late_pulse", {cfg_done, cfg_err}, 0);
        set_uniform(2, 7);
        run_frame(25, 1'b1);

        // Randomized frames, about 40% with one out-of-range field
        for (int k = 0; k < 24; k++) begin
            int fld;
            for (int f = 0; f < N_IN; f++)   f_in[f]  = $urandom_range(0, EXTIN - 1);
            for (int f = 0; f < EXTOUT; f++) f_out[f] = $urandom_range(0, WS + WD - 1);
            if ($urandom_range(0, 99) < 40) begin
                fld = $urandom_range(0, N_IN + EXTOUT - 1);
                if (fld < N_IN) f_in[fld] = $urandom_range(EXTIN, (1 << SEL_PER_IN) - 1);
                else            f_out[fld - N_IN] = $urandom_range(WS + WD, (1 << SEL_PER_OUT) - 1);
            end
            run_frame($urandom_range(0, 60), model_legal());
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
